// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared FSM states, adjust constants and digit sizing helper for bin2bcd_dd
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADJUST = 2'd1,
    SHIFT  = 2'd2,
    DONE   = 2'd3
  } bcd_state_t;

  localparam logic [3:0] ADD3       = 4'd3;
  localparam logic [3:0] ADJ_THRESH = 4'd5;

  // Decimal digits needed to print 2^width-1; valid for width up to 127.
  function automatic int bcd_digits_needed(input int width);
    logic [127:0] v;
    int           n;
    v = (128'd1 << width) - 128'd1;
    n = 0;
    while (v != 128'd0) begin
      v = v / 128'd10;
      n = n + 1;
    end
    return (n == 0) ? 1 : n;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - one BCD digit of the double-dabble adjust step (add 3 when >= 5)
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] adj
);

  assign adj = (digit >= ADJ_THRESH) ? (digit + ADD3) : digit;

endmodule

// File: rtl/bin2bcd_dd.sv
// rtl/bin2bcd_dd.sv - iterative double-dabble binary-to-BCD converter with overflow and done-hold
// Optional signed operand support is enabled by defining BIN2BCD_SIGNED_EN.
module bin2bcd_dd
  import bcd_pkg::*;
#(
  parameter int BIN_W     = 8,
  parameter int DIGITS    = 3,
  parameter int DONE_HOLD = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_init,
  input  logic [BIN_W-1:0]      in_bin,
  input  logic                  in_ack,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_busy,
  output logic                  out_done,
  output logic                  out_ovf,
  output logic                  out_sign
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SCR_W = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int TMR_W = $clog2(DONE_HOLD + 1);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(DONE_HOLD);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

  bcd_state_t        state, state_d;
  logic [SCR_W-1:0]  scratch;
  logic [CNT_W-1:0]  cnt;
  logic [TMR_W-1:0]  tmr;
  logic              ovf;
  logic [BCD_W-1:0]  bcd_q;
  logic              ovf_q;
  logic [BCD_W-1:0]  adj_bcd;
  logic [BIN_W-1:0]  operand;

  // Digits never exceed 12 after adjust, so each one is independent.
  for (genvar k = 0; k < DIGITS; k++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit (scratch[BIN_W + 4*k +: 4]),
      .adj   (adj_bcd[4*k +: 4])
    );
  end

`ifdef BIN2BCD_SIGNED_EN
  logic sign_q;

  assign operand  = in_bin[BIN_W-1] ? ((~in_bin) + {{(BIN_W-1){1'b0}}, 1'b1}) : in_bin;
  assign out_sign = sign_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q <= 1'b0;
    end else if (state == IDLE && in_init) begin
      sign_q <= in_bin[BIN_W-1];
    end
  end
`else
  assign operand  = in_bin;
  assign out_sign = 1'b0;
`endif

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (in_init) state_d = ADJUST;
      ADJUST:  state_d = SHIFT;
      SHIFT:   state_d = (cnt == CNT_ONE) ? DONE : ADJUST;
      DONE:    if (in_ack || tmr == TMR_ONE) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      scratch <= '0;
      cnt     <= '0;
      tmr     <= '0;
      ovf     <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state <= state_d;
      case (state)
        IDLE: begin
          if (in_init) begin
            scratch <= {{BCD_W{1'b0}}, operand};
            cnt     <= CNT_LOAD;
            ovf     <= 1'b0;
          end
        end
        ADJUST: begin
          scratch[SCR_W-1:BIN_W] <= adj_bcd;
        end
        SHIFT: begin
          // The bit leaving the top digit is the carry past 10^DIGITS.
          scratch <= {scratch[SCR_W-2:0], 1'b0};
          cnt     <= cnt - CNT_ONE;
          ovf     <= ovf | scratch[SCR_W-1];
          if (cnt == CNT_ONE) begin
            bcd_q <= scratch[SCR_W-2:BIN_W-1];
            ovf_q <= ovf | scratch[SCR_W-1];
            tmr   <= TMR_LOAD;
          end
        end
        DONE: begin
          tmr <= tmr - TMR_ONE;
        end
        default: ;
      endcase
    end
  end

  assign out_bcd  = bcd_q;
  assign out_ovf  = ovf_q;
  assign out_busy = (state == ADJUST) || (state == SHIFT);
  assign out_done = (state == DONE);

endmodule
